// File: rtl/dav_pkg.sv
//==============================================================================
// Module      : dav_pkg
// Description : Shared types and constants for the sample frame buffer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package dav_pkg;

  localparam int FRAME_LEN_DEFAULT = 64;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
//==============================================================================
// Module      : edge_sync
// Description : Synchronizer chain plus rising-edge detect for an async level.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Loading all 1s hides an input that is already high at reset release.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign strobe = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

`default_nettype wire

// File: rtl/sample_frame_buffer.sv
//==============================================================================
// Module      : sample_frame_buffer
// Description : Captures one sample per sampleClock edge into ping-pong frames
//               and streams completed frames over valid/ready.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sample_frame_buffer
  import dav_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_LEN   = FRAME_LEN_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         sampleClock,
  input  logic [DATA_WIDTH-1:0]        sampleIn,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [DATA_WIDTH-1:0]        outData,
  output logic [$clog2(FRAME_LEN)-1:0] outIndex,
  output logic                         outLast,
  output logic                         overflow
);

  localparam int               IDX_W    = idx_w(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic strobe;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (sampleClock),
    .strobe   (strobe)
  );

  logic [DATA_WIDTH-1:0] mem_q [2][FRAME_LEN];

  logic             wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [1:0]       full_q,    full_d;
  logic             overflow_q, overflow_d;
  rd_state_t        state_q,   state_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] rd_idx_q,  rd_idx_d;

  logic rd_done;
  logic other_free;

  assign rd_done    = (state_q == STREAM) & outReady & (rd_idx_q == LAST_IDX);
  // A bank released by this cycle's final handshake is already free for the swap.
  assign other_free = ~full_q[~wr_bank_q] | (rd_done & (rd_bank_q == ~wr_bank_q));

  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_ptr_d   = wr_ptr_q;
    full_d     = full_q;
    overflow_d = overflow_q;
    if (rd_done) begin
      full_d[rd_bank_q] = 1'b0;
    end
    if (strobe) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_q == LAST_IDX) begin
        if (other_free) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    case (state_q)
      IDLE: begin
        if (|full_q) begin
          state_d   = STREAM;
          rd_bank_d = ~full_q[0];
          rd_idx_d  = '0;
        end
      end
      STREAM: begin
        if (outReady) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      full_q     <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
      rd_bank_q  <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      rd_bank_q  <= rd_bank_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  always_ff @(posedge clock) begin
    if (strobe && !reset) begin
      mem_q[wr_bank_q][wr_ptr_q] <= sampleIn;
    end
  end

  assign outValid = (state_q == STREAM);
  assign outData  = outValid ? mem_q[rd_bank_q][rd_idx_q] : '0;
  assign outIndex = outValid ? rd_idx_q : '0;
  assign outLast  = outValid & (rd_idx_q == LAST_IDX);
  assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_frame_buffer.sv
//==============================================================================
// Module      : tb_sample_frame_buffer
// Description : Directed self-checking bench for sample_frame_buffer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sample_frame_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sampleClock;
  logic [15:0] sampleIn;
  logic        outValid;
  logic        outReady;
  logic [15:0] outData;
  logic [5:0]  outIndex;
  logic        outLast;
  logic        overflow;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sample_frame_buffer #(
    .DATA_WIDTH  (16),
    .FRAME_LEN   (64),
    .SYNC_STAGES (2)
  ) dut (
    .clock       (clk),
    .reset       (reset),
    .sampleClock (sampleClock),
    .sampleIn    (sampleIn),
    .outValid    (outValid),
    .outReady    (outReady),
    .outData     (outData),
    .outIndex    (outIndex),
    .outLast     (outLast),
    .overflow    (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Sample is written on the third high tick (2 sync stages after first sample).
  task automatic high_phase(input int val);
    sampleIn    = 16'(val);
    sampleClock = 1'b1;
    repeat (3) tick();
    sampleClock = 1'b0;
  endtask

  task automatic send(input int val);
    high_phase(val);
    repeat (3) tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(outValid), 32'd0);
    check({tag, "_data"},  32'(outData),  32'd0);
    check({tag, "_index"}, 32'(outIndex), 32'd0);
    check({tag, "_last"},  32'(outLast),  32'd0);
  endtask

  // Consumes n samples of a frame whose values are base+index.
  task automatic collect(input int base, input int n, input bit rnd);
    int  cnt     = 0;
    int  cycles  = 0;
    bit  started = 1'b0;
    logic r;
    while (cnt < n && cycles < 2000) begin
      r        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      outReady = r;
      if (started || outValid) begin
        started = 1'b1;
        check("stream_valid", 32'(outValid), 32'd1);
        check("stream_data",  32'(outData),  32'((base + cnt) & 16'hFFFF));
        check("stream_index", 32'(outIndex), 32'(cnt));
        check("stream_last",  32'(outLast),  32'(cnt == 63));
      end
      if (outValid && r) cnt++;
      tick();
      cycles++;
    end
    outReady = 1'b0;
    check("frame_count", 32'(cnt), 32'(n));
  endtask

  initial begin
    reset       = 1'b1;
    sampleClock = 1'b1;
    sampleIn    = '0;
    outReady    = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    check("reset_overflow", 32'(overflow), 32'd0);

    // sampleClock high across reset release must not count as an edge
    reset = 1'b0;
    repeat (6) tick();
    check_idle("release_high");
    check("release_overflow", 32'(overflow), 32'd0);
    sampleClock = 1'b0;
    repeat (3) tick();

    // Frame 0..63, full-rate drain, one-cycle frame latency
    for (int i = 0; i < 63; i++) send(i);
    high_phase(63);
    check("latency_pre_valid", 32'(outValid), 32'd0);
    tick();
    check("latency_valid", 32'(outValid), 32'd1);
    check("latency_data",  32'(outData),  32'd0);
    collect(0, 64, 1'b0);
    check("frame1_done_valid", 32'(outValid), 32'd0);

    // Random backpressure
    for (int i = 0; i < 64; i++) send(100 + i);
    collect(100, 64, 1'b1);
    check("frame2_done_valid", 32'(outValid), 32'd0);

    // Final handshake coincides with completion of the next frame
    for (int i = 0; i < 64; i++) send(300 + i);
    collect(300, 63, 1'b0);
    check("hold_last",  32'(outLast),  32'd1);
    check("hold_index", 32'(outIndex), 32'd63);
    check("hold_data",  32'(outData),  32'd363);
    for (int i = 0; i < 63; i++) send(400 + i);
    sampleIn    = 16'd463;
    sampleClock = 1'b1;
    tick();
    tick();
    outReady = 1'b1;
    tick();
    outReady    = 1'b0;
    sampleClock = 1'b0;
    check("coincide_overflow", 32'(overflow), 32'd0);
    check("coincide_valid",    32'(outValid), 32'd0);
    tick();
    check("coincide_restart_valid", 32'(outValid), 32'd1);
    check("coincide_restart_index", 32'(outIndex), 32'd0);
    check("coincide_restart_data",  32'(outData),  32'd400);
    collect(400, 64, 1'b0);
    check("coincide_overflow_after", 32'(overflow), 32'd0);

    // Overflow: 128 samples with the consumer stalled
    for (int i = 0; i < 127; i++) send(1000 + i);
    check("overflow_before", 32'(overflow), 32'd0);
    high_phase(1127);
    check("overflow_set", 32'(overflow), 32'd1);
    repeat (3) tick();
    collect(1000, 64, 1'b0);
    repeat (10) tick();
    check("discarded_valid", 32'(outValid), 32'd0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset during write of sample 30
    for (int i = 0; i < 29; i++) send(2000 + i);
    high_phase(2029);
    reset = 1'b1;
    tick();
    check_idle("wr_reset");
    check("wr_reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 64; i++) send(3000 + i);
    collect(3000, 10, 1'b0);
    check("midstream_index", 32'(outIndex), 32'd10);
    check("midstream_data",  32'(outData),  32'd3010);

    // Reset mid-stream
    reset = 1'b1;
    tick();
    check_idle("rd_reset");
    reset = 1'b0;
    repeat (5) tick();
    check("rd_reset_no_resume", 32'(outValid), 32'd0);
    for (int i = 0; i < 64; i++) send(4000 + i);
    collect(4000, 64, 1'b0);
    check("final_valid",    32'(outValid), 32'd0);
    check("final_overflow", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
